// File: rtl/regbus_arbiter_if.sv
// regbus_arbiter_if: requester-side and register-file-side signal bundle for regbus_arbiter
interface regbus_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    req_we;
    logic [NUM_REQ*16-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ*4-1:0]  req_be;
    logic [NUM_REQ-1:0]    ack;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  busy;
    logic                  wr_en;
    logic [3:0]            be;
    logic [15:0]           wr_addr;
    logic [31:0]           wdata;
    logic                  rd_en;
    logic [15:0]           rd_addr;
    logic [31:0]           rdata;
    logic                  rd_rdy;

    modport master (
        input  req, req_we, req_addr, req_wdata, req_be, rdata, rd_rdy,
        output ack, rsp_rdata, rsp_err, busy, wr_en, be, wr_addr, wdata, rd_en, rd_addr
    );

    modport slave (
        output req, req_we, req_addr, req_wdata, req_be, rdata, rd_rdy,
        input  ack, rsp_rdata, rsp_err, busy, wr_en, be, wr_addr, wdata, rd_en, rd_addr
    );
endinterface

// File: rtl/regbus_arbiter.sv
// regbus_arbiter: round-robin arbiter serialising requests onto one register-file port (optional read timeout via ARB_TIMEOUT_EN)
module regbus_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 15
) (
    input logic clk,
    input logic rstb,
    regbus_arbiter_if.master bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, CMD, RD_WAIT, DONE} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] w;
    logic          we;
    logic [IW-1:0] hi;
    logic [IW-1:0] lo;
    logic          hit_hi;
    logic          hit_lo;
    logic [IW-1:0] win;
    logic          sel_we;
    logic [15:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_be;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC < 16) ? 4 : $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYC > 0);
`endif

    // winner is the lowest requester at or above ptr, else the lowest overall; then mux its fields
    always_comb begin
        hi        = '0;
        lo        = '0;
        hit_hi    = 1'b0;
        hit_lo    = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                lo     = IW'(i);
                hit_lo = 1'b1;
                if (IW'(i) >= ptr) begin
                    hi     = IW'(i);
                    hit_hi = 1'b1;
                end
            end
        end
        win = hit_hi ? hi : lo;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == win) begin
                sel_we    = bus.req_we[i];
                sel_addr  = bus.req_addr[16*i +: 16];
                sel_wdata = bus.req_wdata[32*i +: 32];
                sel_be    = bus.req_be[4*i +: 4];
            end
        end
    end

    // arbitration FSM; every bus output is registered and pulses default low each cycle
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state         <= IDLE;
            ptr           <= '0;
            w             <= '0;
            we            <= 1'b0;
            bus.ack       <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.wr_en     <= 1'b0;
            bus.be        <= '0;
            bus.wr_addr   <= '0;
            bus.wdata     <= '0;
            bus.rd_en     <= 1'b0;
            bus.rd_addr   <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt           <= '0;
`endif
        end else begin
            bus.ack       <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.wr_en     <= 1'b0;
            bus.rd_en     <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit_lo) begin
                        w           <= win;
                        we          <= sel_we;
                        bus.wr_addr <= sel_addr;
                        bus.rd_addr <= sel_addr;
                        bus.wdata   <= sel_wdata;
                        bus.be      <= sel_be;
                        bus.wr_en   <= sel_we;
                        bus.rd_en   <= ~sel_we;
                        bus.busy    <= 1'b1;
                        state       <= CMD;
                    end
                end
                CMD: begin
                    if (we) begin
                        bus.ack <= NUM_REQ'(1) << w;
                        state   <= DONE;
                    end else begin
                        state   <= RD_WAIT;
                    end
`ifdef ARB_TIMEOUT_EN
                    cnt <= '0;
`endif
                end
                RD_WAIT: begin
                    if (bus.rd_rdy) begin
                        bus.rsp_rdata <= bus.rdata;
                        bus.ack       <= NUM_REQ'(1) << w;
                        state         <= DONE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                        bus.rsp_rdata <= 32'hDEAD_BEEF;
                        bus.rsp_err   <= 1'b1;
                        bus.ack       <= NUM_REQ'(1) << w;
                        state         <= DONE;
                    end
                    cnt <= cnt + 1'b1;
`endif
                end
                DONE: begin
                    ptr      <= (w == IW'(NUM_REQ - 1)) ? '0 : w + 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
